// File: rtl/mem_stage.sv
// Memory stage: EXE/MEM register, word-addressed data memory with optional
// wait states, and the MEM/WB register that feeds writeback and forwarding.
module mem_stage #(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exe_valid,
    input  logic        exe_mem_read,
    input  logic        exe_mem_write,
    input  logic        exe_wb_en,
    input  logic [4:0]  exe_dest,
    input  logic [31:0] ALU_result,
    input  logic [31:0] exe_store_data,
    output logic        mem_stall,
    output logic [31:0] ALU_result_to_mem,
    output logic [4:0]  mem_dest,
    output logic        mem_wb_en,
    output logic        wb_valid,
    output logic        wb_en,
    output logic [4:0]  wb_dest,
    output logic [31:0] write_value_to_ID,
    output logic        mem_addr_err
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    logic        em_valid_q, em_valid_d;
    logic        em_rd_q, em_rd_d;
    logic        em_wr_q, em_wr_d;
    logic        em_wb_en_q, em_wb_en_d;
    logic [4:0]  em_dest_q, em_dest_d;
    logic [31:0] em_alu_q, em_alu_d;
    logic [31:0] em_sd_q, em_sd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wb_valid_q, wb_valid_d;
    logic        wb_en_q, wb_en_d;
    logic [4:0]  wb_dest_q, wb_dest_d;
    logic [31:0] wb_val_q, wb_val_d;
    logic        err_q, err_d;

    logic [31:0]       mem_q [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic              is_mem;
    logic              is_load;
    logic              in_range;
    logic              busy;
    logic [31:0]       load_data;
    logic              store_commit;

    assign idx      = em_alu_q[ADDR_W-1:0];
    assign is_mem   = em_rd_q | em_wr_q;
    assign is_load  = em_rd_q & ~em_wr_q;
    assign in_range = (em_alu_q >> ADDR_W) == 32'd0;

    // Stall handshake: while mem_stall=1 the stage accepts nothing and EXE/ID
    // must hold their outputs; an instruction is accepted at an edge where
    // exe_valid=1 and mem_stall=0, and leaves to WB at the first unstalled edge.
    generate
        if (WAIT_STATES == 0) begin : g_no_wait
            assign busy = 1'b0;
        end else begin : g_wait
            assign busy = cnt_q < WS;
        end
    endgenerate

    assign mem_stall = em_valid_q & is_mem & busy;
    assign load_data = in_range ? mem_q[idx] : 32'd0;
    assign store_commit = rst_n & ~mem_stall & em_valid_q & em_wr_q & in_range;

    always_comb begin
        em_valid_d = em_valid_q;
        em_rd_d    = em_rd_q;
        em_wr_d    = em_wr_q;
        em_wb_en_d = em_wb_en_q;
        em_dest_d  = em_dest_q;
        em_alu_d   = em_alu_q;
        em_sd_d    = em_sd_q;
        cnt_d      = cnt_q;
        wb_valid_d = wb_valid_q;
        wb_en_d    = wb_en_q;
        wb_dest_d  = wb_dest_q;
        wb_val_d   = wb_val_q;
        err_d      = err_q;
        if (mem_stall) begin
            cnt_d      = cnt_q + 4'd1;
            wb_valid_d = 1'b0;
            wb_en_d    = 1'b0;
        end else begin
            em_valid_d = exe_valid;
            cnt_d      = 4'd0;
            if (exe_valid) begin
                em_rd_d    = exe_mem_read;
                em_wr_d    = exe_mem_write;
                em_wb_en_d = exe_wb_en;
                em_dest_d  = exe_dest;
                em_alu_d   = ALU_result;
                em_sd_d    = exe_store_data;
            end
            wb_valid_d = em_valid_q;
            wb_en_d    = em_valid_q & em_wb_en_q & (em_dest_q != 5'd0);
            wb_dest_d  = em_dest_q;
            wb_val_d   = is_load ? load_data : em_alu_q;
            if (em_valid_q && is_mem && !in_range) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            em_valid_q <= 1'b0;
            em_rd_q    <= 1'b0;
            em_wr_q    <= 1'b0;
            em_wb_en_q <= 1'b0;
            em_dest_q  <= 5'd0;
            em_alu_q   <= 32'd0;
            em_sd_q    <= 32'd0;
            cnt_q      <= 4'd0;
            wb_valid_q <= 1'b0;
            wb_en_q    <= 1'b0;
            wb_dest_q  <= 5'd0;
            wb_val_q   <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            em_valid_q <= em_valid_d;
            em_rd_q    <= em_rd_d;
            em_wr_q    <= em_wr_d;
            em_wb_en_q <= em_wb_en_d;
            em_dest_q  <= em_dest_d;
            em_alu_q   <= em_alu_d;
            em_sd_q    <= em_sd_d;
            cnt_q      <= cnt_d;
            wb_valid_q <= wb_valid_d;
            wb_en_q    <= wb_en_d;
            wb_dest_q  <= wb_dest_d;
            wb_val_q   <= wb_val_d;
            err_q      <= err_d;
        end
    end

    // Array has no reset; a store still in wait states when reset hits is lost.
    always_ff @(posedge clk) begin
        if (store_commit) begin
            mem_q[idx] <= em_sd_q;
        end
    end

    assign ALU_result_to_mem = em_alu_q;
    assign mem_dest          = em_dest_q;
    assign mem_wb_en         = em_wb_en_q & em_valid_q;
    assign wb_valid          = wb_valid_q;
    assign wb_en             = wb_en_q;
    assign wb_dest           = wb_dest_q;
    assign write_value_to_ID = wb_val_q;
    assign mem_addr_err      = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: three instances (0, 2 and 3 wait states) share
// the stimulus; sel picks whose outputs the current test observes.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        exe_valid = 1'b0;
  logic        exe_mem_read = 1'b0;
  logic        exe_mem_write = 1'b0;
  logic        exe_wb_en = 1'b0;
  logic [4:0]  exe_dest = 5'd0;
  logic [31:0] alu_result = 32'd0;
  logic [31:0] store_data = 32'd0;

  logic [2:0]        stall_v, mwb_v, wbv_v, wben_v, err_v;
  logic [2:0][31:0]  fwd_v, val_v;
  logic [2:0][4:0]   mdest_v, wdest_v;

  logic [1:0]  sel = 2'd0;
  logic        stall, mwb, wbv, wben, err;
  logic [31:0] fwd, val;
  logic [4:0]  mdest, wdest;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int WS = (g == 0) ? 0 : g + 1;
    mem_stage #(.DEPTH(256), .ADDR_W(8), .WAIT_STATES(WS)) u_dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .exe_valid         (exe_valid),
      .exe_mem_read      (exe_mem_read),
      .exe_mem_write     (exe_mem_write),
      .exe_wb_en         (exe_wb_en),
      .exe_dest          (exe_dest),
      .ALU_result        (alu_result),
      .exe_store_data    (store_data),
      .mem_stall         (stall_v[g]),
      .ALU_result_to_mem (fwd_v[g]),
      .mem_dest          (mdest_v[g]),
      .mem_wb_en         (mwb_v[g]),
      .wb_valid          (wbv_v[g]),
      .wb_en             (wben_v[g]),
      .wb_dest           (wdest_v[g]),
      .write_value_to_ID (val_v[g]),
      .mem_addr_err      (err_v[g])
    );
  end

  always_comb begin
    stall = stall_v[sel];
    mwb   = mwb_v[sel];
    wbv   = wbv_v[sel];
    wben  = wben_v[sel];
    err   = err_v[sel];
    fwd   = fwd_v[sel];
    val   = val_v[sel];
    mdest = mdest_v[sel];
    wdest = wdest_v[sel];
  end

  task automatic drive(input logic rd, input logic wr, input logic wbe,
                       input logic [4:0] d, input logic [31:0] a, input logic [31:0] sd);
    exe_valid = 1'b1;
    exe_mem_read = rd;
    exe_mem_write = wr;
    exe_wb_en = wbe;
    exe_dest = d;
    alu_result = a;
    store_data = sd;
  endtask

  task automatic idle_inputs();
    exe_valid = 1'b0;
    exe_mem_read = 1'b0;
    exe_mem_write = 1'b0;
    exe_wb_en = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // Presents one instruction, waits out any stall, returns after it is accepted.
  task automatic issue(input logic rd, input logic wr, input logic wbe,
                       input logic [4:0] d, input logic [31:0] a, input logic [31:0] sd);
    int n;
    drive(rd, wr, wbe, d, a, sd);
    n = 0;
    while (stall !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (stall !== 1'b0) $display("FAIL issue_wait: stall=%0b after %0d cycles, want 0", stall, n);
    else n_pass++;
    n_total++;
    step();
    idle_inputs();
  endtask

  task automatic wait_wb();
    int n;
    n = 0;
    while (wbv !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (wbv !== 1'b1) $display("FAIL wait_wb: wb_valid=%0b after %0d cycles, want 1", wbv, n);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_reset();
    sel = 2'd0;
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 5'd5, 32'h55, 32'h66);
    step();
    step();
    if (stall !== 1'b0) $display("FAIL reset_stall: got %0b want 0", stall); else n_pass++; n_total++;
    if (fwd !== 32'd0) $display("FAIL reset_fwd: got %h want 0", fwd); else n_pass++; n_total++;
    if (mdest !== 5'd0) $display("FAIL reset_mem_dest: got %0d want 0", mdest); else n_pass++; n_total++;
    if (mwb !== 1'b0) $display("FAIL reset_mem_wb_en: got %0b want 0", mwb); else n_pass++; n_total++;
    if (wbv !== 1'b0) $display("FAIL reset_wb_valid: got %0b want 0", wbv); else n_pass++; n_total++;
    if (wben !== 1'b0) $display("FAIL reset_wb_en: got %0b want 0", wben); else n_pass++; n_total++;
    if (wdest !== 5'd0) $display("FAIL reset_wb_dest: got %0d want 0", wdest); else n_pass++; n_total++;
    if (val !== 32'd0) $display("FAIL reset_wb_value: got %h want 0", val); else n_pass++; n_total++;
    if (err !== 1'b0) $display("FAIL reset_addr_err: got %0b want 0", err); else n_pass++; n_total++;
    idle_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_alu();
    sel = 2'd0;
    drive(1'b0, 1'b0, 1'b1, 5'd5, 32'h12345678, 32'h0);
    step();
    idle_inputs();
    if (fwd !== 32'h12345678) $display("FAIL alu_fwd: got %h want 12345678", fwd); else n_pass++; n_total++;
    if (mdest !== 5'd5) $display("FAIL alu_mem_dest: got %0d want 5", mdest); else n_pass++; n_total++;
    if (mwb !== 1'b1) $display("FAIL alu_mem_wb_en: got %0b want 1", mwb); else n_pass++; n_total++;
    if (wbv !== 1'b0) $display("FAIL alu_wb_early: got %0b want 0", wbv); else n_pass++; n_total++;
    step();
    if (wbv !== 1'b1) $display("FAIL alu_wb_valid: got %0b want 1", wbv); else n_pass++; n_total++;
    if (wben !== 1'b1) $display("FAIL alu_wb_en: got %0b want 1", wben); else n_pass++; n_total++;
    if (wdest !== 5'd5) $display("FAIL alu_wb_dest: got %0d want 5", wdest); else n_pass++; n_total++;
    if (val !== 32'h12345678) $display("FAIL alu_wb_value: got %h want 12345678", val); else n_pass++; n_total++;
    if (mwb !== 1'b0) $display("FAIL alu_bubble_mem_wb_en: got %0b want 0", mwb); else n_pass++; n_total++;
  endtask

  task automatic test_store_load();
    sel = 2'd0;
    drive(1'b0, 1'b1, 1'b0, 5'd0, 32'd7, 32'hDEADBEEF);
    step();
    drive(1'b1, 1'b0, 1'b1, 5'd3, 32'd7, 32'h0);
    step();
    idle_inputs();
    if (wbv !== 1'b1) $display("FAIL st_wb_valid: got %0b want 1", wbv); else n_pass++; n_total++;
    if (wben !== 1'b0) $display("FAIL st_wb_en: got %0b want 0", wben); else n_pass++; n_total++;
    if (val !== 32'd7) $display("FAIL st_wb_value: got %h want 7", val); else n_pass++; n_total++;
    step();
    if (val !== 32'hDEADBEEF) $display("FAIL ld_value: got %h want deadbeef", val); else n_pass++; n_total++;
    if (wdest !== 5'd3) $display("FAIL ld_wb_dest: got %0d want 3", wdest); else n_pass++; n_total++;
    if (wben !== 1'b1) $display("FAIL ld_wb_en: got %0b want 1", wben); else n_pass++; n_total++;
    if (err !== 1'b0) $display("FAIL ld_addr_err: got %0b want 0", err); else n_pass++; n_total++;
  endtask

  task automatic test_back_to_back();
    sel = 2'd0;
    drive(1'b0, 1'b0, 1'b1, 5'd1, 32'h11, 32'h0);
    step();
    drive(1'b0, 1'b0, 1'b1, 5'd0, 32'h22, 32'h0);
    step();
    drive(1'b0, 1'b0, 1'b1, 5'd31, 32'h33, 32'h0);
    if (val !== 32'h11 || wdest !== 5'd1 || wben !== 1'b1)
      $display("FAIL b2b_first: got %h/%0d/%0b want 11/1/1", val, wdest, wben);
    else n_pass++;
    n_total++;
    step();
    idle_inputs();
    if (val !== 32'h22 || wbv !== 1'b1) $display("FAIL b2b_second: got %h/%0b want 22/1", val, wbv); else n_pass++; n_total++;
    if (wben !== 1'b0) $display("FAIL b2b_dest0_wb_en: got %0b want 0", wben); else n_pass++; n_total++;
    step();
    if (val !== 32'h33 || wdest !== 5'd31 || wben !== 1'b1)
      $display("FAIL b2b_third: got %h/%0d/%0b want 33/31/1", val, wdest, wben);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_addr_err();
    sel = 2'd0;
    do_reset();
    issue(1'b1, 1'b0, 1'b1, 5'd4, 32'd256, 32'h0);
    step();
    if (val !== 32'd0) $display("FAIL oor_load_value: got %h want 0", val); else n_pass++; n_total++;
    if (err !== 1'b1) $display("FAIL oor_addr_err: got %0b want 1", err); else n_pass++; n_total++;
    issue(1'b0, 1'b1, 1'b0, 5'd0, 32'd263, 32'h5);
    issue(1'b1, 1'b0, 1'b1, 5'd9, 32'd7, 32'h0);
    step();
    if (val !== 32'hDEADBEEF) $display("FAIL oor_store_dropped: got %h want deadbeef", val); else n_pass++; n_total++;
    if (err !== 1'b1) $display("FAIL oor_err_sticky: got %0b want 1", err); else n_pass++; n_total++;
  endtask

  task automatic test_wait_states();
    sel = 2'd1;
    do_reset();
    issue(1'b0, 1'b1, 1'b0, 5'd0, 32'd4, 32'hCAFE0004);
    repeat (4) step();
    drive(1'b1, 1'b0, 1'b1, 5'd6, 32'd4, 32'h0);
    step();
    drive(1'b0, 1'b0, 1'b1, 5'd8, 32'h77, 32'h0);
    if (stall !== 1'b1) $display("FAIL ws_stall_c1: got %0b want 1", stall); else n_pass++; n_total++;
    if (wbv !== 1'b0) $display("FAIL ws_wb_c1: got %0b want 0", wbv); else n_pass++; n_total++;
    step();
    if (stall !== 1'b1) $display("FAIL ws_stall_c2: got %0b want 1", stall); else n_pass++; n_total++;
    if (wbv !== 1'b0) $display("FAIL ws_wb_c2: got %0b want 0", wbv); else n_pass++; n_total++;
    if (fwd !== 32'd4) $display("FAIL ws_hold_c2: got %h want 4", fwd); else n_pass++; n_total++;
    step();
    if (stall !== 1'b0) $display("FAIL ws_stall_c3: got %0b want 0", stall); else n_pass++; n_total++;
    if (wbv !== 1'b0) $display("FAIL ws_wb_c3: got %0b want 0", wbv); else n_pass++; n_total++;
    if (fwd !== 32'd4) $display("FAIL ws_hold_c3: got %h want 4", fwd); else n_pass++; n_total++;
    step();
    idle_inputs();
    if (wbv !== 1'b1 || val !== 32'hCAFE0004 || wdest !== 5'd6)
      $display("FAIL ws_load_wb: got %0b/%h/%0d want 1/cafe0004/6", wbv, val, wdest);
    else n_pass++;
    n_total++;
    if (fwd !== 32'h77 || stall !== 1'b0) $display("FAIL ws_alu_accept: got %h/%0b want 77/0", fwd, stall); else n_pass++; n_total++;
    step();
    if (val !== 32'h77 || wdest !== 5'd8) $display("FAIL ws_alu_wb: got %h/%0d want 77/8", val, wdest); else n_pass++; n_total++;
  endtask

  task automatic test_reset_mid();
    sel = 2'd2;
    do_reset();
    issue(1'b0, 1'b1, 1'b0, 5'd0, 32'd9, 32'hAA);
    repeat (5) step();
    drive(1'b0, 1'b1, 1'b0, 5'd0, 32'd9, 32'h1);
    step();
    idle_inputs();
    if (stall !== 1'b1) $display("FAIL rm_stall: got %0b want 1", stall); else n_pass++; n_total++;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    if (stall !== 1'b0) $display("FAIL rm_stall_cleared: got %0b want 0", stall); else n_pass++; n_total++;
    issue(1'b1, 1'b0, 1'b1, 5'd2, 32'd9, 32'h0);
    wait_wb();
    if (val !== 32'hAA) $display("FAIL rm_load_value: got %h want aa", val); else n_pass++; n_total++;
    if (wdest !== 5'd2) $display("FAIL rm_wb_dest: got %0d want 2", wdest); else n_pass++; n_total++;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store_load();
    test_back_to_back();
    test_addr_err();
    test_wait_states();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage pipeline, directly downstream of the execute stage.
- Latches EXE outputs into the EXE/MEM register and performs load/store on a word-addressed data memory. The address is the ALU result, already a word index (EXE_CMD 16 produces it).
- Inserts configurable wait states with a stall handshake, then drives the MEM/WB register.
- Exports the forwarding taps the EXE operand muxes consume: ALU_result_to_mem and write_value_to_ID.

Parameters:
DEPTH, 256, data memory size in 32-bit words (power of two)
ADDR_W, 8, log2(DEPTH); index bits compared against DEPTH
WAIT_STATES, 0, extra cycles a load/store occupies MEM (0..15)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
exe_valid  in  1  EXE presents an instruction this cycle
exe_mem_read  in  1  instruction is a load
exe_mem_write  in  1  instruction is a store
exe_wb_en  in  1  instruction writes the register file
exe_dest  in  5  destination register
ALU_result  in  32  EXE result; word index for load/store
exe_store_data  in  32  store data
mem_stall  out  1  MEM busy; EXE/ID must hold, new input not accepted
ALU_result_to_mem  out  32  EXE/MEM-latched ALU result (forward tap)
mem_dest  out  5  EXE/MEM-latched dest (hazard unit)
mem_wb_en  out  1  EXE/MEM-latched wb_en AND em_valid
wb_valid  out  1  MEM/WB register holds an instruction
wb_en  out  1  register-file write enable to WB
wb_dest  out  5  WB destination register
write_value_to_ID  out  32  WB value: load data or ALU result (forward tap)
mem_addr_err  out  1  sticky: some load/store used index >= DEPTH

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - Clears em_valid, em_*, cnt, wb_valid, wb_en, wb_dest, write_value_to_ID, ALU_result_to_mem, mem_dest, mem_wb_en and mem_addr_err to 0.
  - Memory array is not reset.
  - A pending store in wait states is abandoned and not committed.
- Accept: at an edge where exe_valid=1 and mem_stall=0, the EXE/MEM register loads all exe_* inputs, sets em_valid=1 and sets cnt=0. If exe_valid=0 and mem_stall=0, em_valid becomes 0 (bubble).
- Mem op: em_mem_read or em_mem_write. If both are set, the instruction is a store; write_value_to_ID = ALU result.
- mem_stall is combinational: em_valid AND mem op AND cnt < WAIT_STATES. It is never asserted for ALU-only instructions or when WAIT_STATES=0.
- While stalled:
  - The EXE/MEM register holds its contents.
  - cnt increments each edge.
  - The MEM/WB register loads a bubble (wb_valid=0, wb_en=0).
- Transfer: at an edge with mem_stall=0, the MEM/WB register loads:
  - wb_valid=em_valid.
  - wb_en = em_valid AND em_wb_en AND em_dest != 0.
  - wb_dest=em_dest.
  - write_value_to_ID = load data if em_mem_read and not a store, else ALU result.
- Store commit: mem[index] <= store data on the transfer edge only. No partial writes.
- Load read: combinational from the array at the transfer edge, so a load entering the cycle after a store to the same index returns the new data.
- Out-of-range index (>= DEPTH; only index bits above ADDR_W can trip this): the store is dropped, the load returns 0, and mem_addr_err is set on the transfer edge. mem_addr_err stays set until reset.
- Latency:
  - An ALU or mem op accepted at edge E appears in the WB outputs after edge E+1+WAIT_STATES (mem op).
  - ALU ops appear after edge E+1.
- Back-to-back accepted instructions with no stall give one WB result per cycle.

Test Plan:
- Reset, WAIT_STATES=0: hold rst_n=0 two cycles with exe_valid=1 -> every output is 0 and mem_stall=0.
- ALU pass-through: accept ALU_result=0x12345678, wb_en=1, dest=5 -> ALU_result_to_mem=0x12345678 after 1 edge; wb_en=1, wb_dest=5, write_value_to_ID=0x12345678 after 2 edges.
- Store then load, WAIT_STATES=0: store 0xDEADBEEF to index 7, next cycle load index 7 to dest 3 -> write_value_to_ID=0xDEADBEEF and wb_dest=3 one cycle after the store's WB.
- Wait states, WAIT_STATES=2: accept load -> mem_stall=1 for exactly 2 cycles and wb_valid=0 during them; following ALU op held at input and accepted on the third cycle.
- Reset mid-operation, WAIT_STATES=3: store 0x1 to index 9, assert reset during the first stall cycle -> a later load of index 9 returns the prior value (0xAA pre-written), not 0x1.
- Boundaries:
  - load index 256 with DEPTH=256 -> value 0 and mem_addr_err=1 sticky.
  - dest=0 with wb_en=1 -> wb_en=0.
